ps2_host_tx: RTL and testbench

- Host-to-device PS/2 command transmitter; the write direction of the PS/2 link whose device-to-host side feeds mouse xpos/ypos/mouse_left.
- Sends one command byte to the mouse (e.g. 0xF4 enable reporting, 0xFF reset), then checks the device acknowledge bit.
- Lives inside MOUSE on the 130 MHz mouse clock. It drives the shared ps2_clk/ps2_data lines through open-drain enables; the top level owns the tristate buffers.

---
 rtl/ps2_host_tx.sv | 206 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the bus, shifts out one framed byte, then checks the device ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 14300,
  parameter int SETUP_CYCLES   = 260,
  parameter int TIMEOUT_CYCLES = 1950000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam int SN = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int MAX_A =
    (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int MAX_C =
    (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] INH_END = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] SET_END = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] TO_END  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_SETUP,
    S_SEND,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t state, state_n;

  logic [SN-1:0] clk_sync;
  logic [SN-1:0] dat_sync;
  logic          clk_prev;
  logic          clk_s;
  logic          dat_s;
  logic          fall;

  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bit_cnt, bit_n;
  logic [8:0]    shreg, sh_n;

  logic clk_oe_n;
  logic dat_oe_n;
  logic busy_n;
  logic done_n;
  logic ack_n;
  logic err_n;
  logic timeout;
  logic abort;

  assign clk_s   = clk_sync[SN-1];
  assign dat_s   = dat_sync[SN-1];
  assign fall    = clk_prev & ~clk_s;
  assign timeout = (cnt == TO_END);

  // Bring the bus lines into the clk domain; idle bus level is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SN-2:0], ps2_clk_in};
      dat_sync <= {dat_sync[SN-2:0], ps2_data_in};
      clk_prev <= clk_s;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_cnt     <= bit_n;
      shreg       <= sh_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= dat_oe_n;
      busy        <= busy_n;
      done        <= done_n;
      ack_ok      <= ack_n;
      error       <= err_n;
    end
  end

  // Next-state and next-output logic for the transmit sequence.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    bit_n    = bit_cnt;
    sh_n     = shreg;
    clk_oe_n = ps2_clk_oe;
    dat_oe_n = ps2_data_oe;
    busy_n   = busy;
    done_n   = 1'b0;
    ack_n    = ack_ok;
    err_n    = error;
    abort    = 1'b0;

    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (tx_start) begin
          sh_n     = {~^tx_data, tx_data};
          busy_n   = 1'b1;
          err_n    = 1'b0;
          ack_n    = 1'b0;
          clk_oe_n = 1'b1;
          dat_oe_n = 1'b0;
          state_n  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt == INH_END) begin
          dat_oe_n = 1'b1;
          state_n  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == SET_END) begin
          clk_oe_n = 1'b0;
          bit_n    = '0;
          state_n  = S_SEND;
        end
      end
      S_SEND: begin
        if (fall) begin
          cnt_n = '0;
          if (bit_cnt < 4'd9) begin
            dat_oe_n = ~shreg[0];
            sh_n     = {1'b0, shreg[8:1]};
            bit_n    = bit_cnt + 4'd1;
          end else begin
            dat_oe_n = 1'b0;
            state_n  = S_ACK;
          end
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      S_ACK: begin
        if (fall) begin
          cnt_n   = '0;
          ack_n   = ~dat_s;
          err_n   = dat_s;
          state_n = S_RELEASE;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      S_RELEASE: begin
        if (timeout) begin
          abort = 1'b1;
        end else if (clk_s && dat_s) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else if (fall) begin
          cnt_n = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (abort) begin
      clk_oe_n = 1'b0;
      dat_oe_n = 1'b0;
      err_n    = 1'b1;
      ack_n    = 1'b0;
      done_n   = 1'b1;
      busy_n   = 1'b0;
      state_n  = S_IDLE;
    end

    if (state_n != state) begin
      cnt_n = '0;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model driving clocks at 1/40 clk.
// Checks framed bits, ack/error, inhibit timing, timeout and reset.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int SET  = 4;
  localparam int TO   = 500;
  localparam int SYNC = 2;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       clk_oe, data_oe, busy, done, ack_ok, error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_fall = 0;

  assign ps2_clk_in  = ~(clk_oe | dev_clk_low);
  assign ps2_data_in = ~(data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES(SET),
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .ps2_clk_oe(clk_oe),
    .ps2_data_oe(data_oe),
    .busy(busy),
    .done(done),
    .ack_ok(ack_ok),
    .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected 11-bit frame as the device sees it: start, LSB-first data,
  // odd parity, stop; bit 0 of the result is the start bit.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic device(input int nclk, input bit give_ack,
                        output logic [10:0] bits, output bit ok);
    int t;
    bits = '1;
    ok = 1'b0;
    t = 0;
    while (ps2_clk_in !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) return;
    t = 0;
    while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) return;
    ok = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    for (int k = 0; k < nclk; k++) begin
      if (k < 11) bits[k] = ps2_data_in;
      if (k == 10 && give_ack) begin
        dev_data_low = 1'b1;
        repeat (5) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      last_fall = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit seen,
                           output logic a, output logic e,
                           output logic bz, output logic oc,
                           output logic od, output int dcyc);
    seen = 1'b0;
    a = 1'bx;
    e = 1'bx;
    bz = 1'bx;
    oc = 1'bx;
    od = 1'bx;
    dcyc = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        a = ack_ok;
        e = error;
        bz = busy;
        oc = clk_oe;
        od = data_oe;
        dcyc = cyc;
        return;
      end
    end
  endtask

  task automatic xfer(input logic [7:0] b, input int nclk,
                      input bit give_ack, output logic [10:0] bits,
                      output bit dev_ok, output bit seen,
                      output logic a, output logic e, output logic bz,
                      output logic oc, output logic od, output int dcyc);
    fork
      device(nclk, give_ack, bits, dev_ok);
      begin
        @(negedge clk);
        tx_data = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_done(3000, seen, a, e, bz, oc, od, dcyc);
      end
    join
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [10:0] bits;
    bit ok;
    bit saw_done;
    rst = 1'b0;
    tx_start = 1'b0;
    tx_data = 8'h00;
    #1;
    vectors++;
    if ({clk_oe, data_oe, busy, done, ack_ok, error} !== 6'b0) begin
      $display("FAIL reset_state: got %b want 000000",
               {clk_oe, data_oe, busy, done, ack_ok, error});
      miscompares++;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    fork
      device(4, 1'b0, bits, ok);
      begin
        @(negedge clk);
        tx_data = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    vectors++;
    if (!ok || busy !== 1'b1 || data_oe !== 1'b1) begin
      $display("FAIL reset_pre: dev_ok=%0d busy=%b data_oe=%b want 1 1 1",
               ok, busy, data_oe);
      miscompares++;
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({clk_oe, data_oe, busy, done} !== 4'b0) begin
      $display("FAIL reset_async: got %b want 0000",
               {clk_oe, data_oe, busy, done});
      miscompares++;
    end
    saw_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    rst = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done || {clk_oe, data_oe, busy, error} !== 4'b0) begin
      $display("FAIL reset_after: done_seen=%0d oe/busy/err=%b want 0 0000",
               saw_done, {clk_oe, data_oe, busy, error});
      miscompares++;
    end
  endtask

  task automatic test_send_f4;
    logic [10:0] bits;
    bit ok, seen;
    logic a, e, bz, oc, od;
    int dc;
    int n;
    bit both;
    n = 0;
    both = 1'b0;
    fork
      xfer(8'hF4, 11, 1'b1, bits, ok, seen, a, e, bz, oc, od, dc);
      begin
        int t;
        t = 0;
        while (clk_oe !== 1'b1 && t < 100) begin
          @(negedge clk);
          t++;
        end
        while (clk_oe === 1'b1 && data_oe !== 1'b1 && n < 100) begin
          n++;
          @(negedge clk);
        end
        both = (clk_oe === 1'b1 && data_oe === 1'b1);
      end
    join
    vectors++;
    if (n != INH || !both) begin
      $display("FAIL inhibit_f4: clk-only cycles=%0d then both=%0d want %0d 1",
               n, both, INH);
      miscompares++;
    end
    vectors++;
    if (!ok || bits !== frame_of(8'hF4)) begin
      $display("FAIL frame_f4: dev_ok=%0d got %b want %b",
               ok, bits, frame_of(8'hF4));
      miscompares++;
    end
    vectors++;
    if (!seen || a !== 1'b1 || e !== 1'b0 || bz !== 1'b0) begin
      $display("FAIL done_f4: seen=%0d ack=%b err=%b busy=%b want 1 1 0 0",
               seen, a, e, bz);
      miscompares++;
    end
  endtask

  task automatic test_parity;
    logic [10:0] bits;
    bit ok, seen;
    logic a, e, bz, oc, od;
    int dc;
    logic [7:0] pat [2];
    pat[0] = 8'hFF;
    pat[1] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      xfer(pat[i], 11, 1'b1, bits, ok, seen, a, e, bz, oc, od, dc);
      vectors++;
      if (!ok || bits[9] !== 1'b1 || bits !== frame_of(pat[i])) begin
        $display("FAIL parity_%h: got %b want %b", pat[i], bits,
                 frame_of(pat[i]));
        miscompares++;
      end
      vectors++;
      if (!seen || a !== 1'b1 || e !== 1'b0) begin
        $display("FAIL done_%h: seen=%0d ack=%b err=%b want 1 1 0",
                 pat[i], seen, a, e);
        miscompares++;
      end
    end
  endtask

  task automatic test_no_ack;
    logic [10:0] bits;
    bit ok, seen;
    logic a, e, bz, oc, od;
    int dc;
    xfer(8'h55, 11, 1'b0, bits, ok, seen, a, e, bz, oc, od, dc);
    vectors++;
    if (!ok || bits !== frame_of(8'h55)) begin
      $display("FAIL frame_noack: got %b want %b", bits, frame_of(8'h55));
      miscompares++;
    end
    vectors++;
    if (!seen || a !== 1'b0 || e !== 1'b1 || bz !== 1'b0) begin
      $display("FAIL done_noack: seen=%0d ack=%b err=%b busy=%b want 1 0 1 0",
               seen, a, e, bz);
      miscompares++;
    end
  endtask

  task automatic test_timeout;
    logic [10:0] bits;
    bit ok, seen;
    logic a, e, bz, oc, od;
    int dc;
    int delta;
    xfer(8'h00, 4, 1'b0, bits, ok, seen, a, e, bz, oc, od, dc);
    delta = dc - last_fall;
    vectors++;
    if (!ok || !seen || delta < TO || delta > TO + SYNC + 3) begin
      $display("FAIL timeout_lat: seen=%0d cycles=%0d want %0d..%0d",
               seen, delta, TO, TO + SYNC + 3);
      miscompares++;
    end
    vectors++;
    if ({oc, od, a, e, bz} !== 5'b00010) begin
      $display("FAIL timeout_out: oe/ack/err/busy=%b want 00010",
               {oc, od, a, e, bz});
      miscompares++;
    end
  endtask

  task automatic test_busy_ignore;
    logic [10:0] bits;
    bit ok, seen;
    logic a, e, bz, oc, od;
    int dc;
    logic busy_seen;
    busy_seen = 1'b0;
    fork
      xfer(8'hF4, 11, 1'b1, bits, ok, seen, a, e, bz, oc, od, dc);
      begin
        repeat (100) @(negedge clk);
        busy_seen = busy;
        tx_data = 8'hAA;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    vectors++;
    if (busy_seen !== 1'b1 || !ok || bits !== frame_of(8'hF4)) begin
      $display("FAIL busy_ignore: busy=%b got %b want %b",
               busy_seen, bits, frame_of(8'hF4));
      miscompares++;
    end
    xfer(8'hAA, 11, 1'b1, bits, ok, seen, a, e, bz, oc, od, dc);
    vectors++;
    if (!ok || bits !== frame_of(8'hAA) || !seen || a !== 1'b1) begin
      $display("FAIL after_busy: got %b ack=%b want %b 1",
               bits, a, frame_of(8'hAA));
      miscompares++;
    end
  endtask

  task automatic test_random;
    logic [10:0] bits;
    bit ok, seen;
    logic a, e, bz, oc, od;
    int dc;
    logic [7:0] b;
    bit ak;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      ak = 1'($urandom_range(0, 1));
      xfer(b, 11, ak, bits, ok, seen, a, e, bz, oc, od, dc);
      vectors++;
      if (!ok || bits !== frame_of(b)) begin
        $display("FAIL rand_frame_%h: got %b want %b", b, bits, frame_of(b));
        miscompares++;
      end
      vectors++;
      if (!seen || a !== ak || e !== !ak || bz !== 1'b0) begin
        $display("FAIL rand_done_%h: seen=%0d ack=%b err=%b want 1 %b %b",
                 b, seen, a, e, ak, !ak);
        miscompares++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_send_f4();
    test_parity();
    test_no_ack();
    test_timeout();
    test_busy_ignore();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
